// File: rtl/spc7110_regs.sv
// SPC7110 register block: banked SRAM/DROM block-select registers and the direct data-ROM port.
// Define SPC7110_DIRECT_PORT_EN to build the direct data port ($4810-$481A); without it that window reads 0.
module spc7110_regs #(
   parameter logic [23:0] DROM_BASE = 24'h100000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [7:0]  SNES_ADDR,
   input  logic [7:0]  SNES_DATA_IN,
   output logic [7:0]  SNES_DATA_OUT,
   input  logic        SNES_RD_END,
   input  logic        SNES_WR_END,
   input  logic        spc7110_direct_enable,
   input  logic        spc7110_banked_enable,
   output logic        spc7110_sram_enable,
   output logic [2:0]  spc7110_blockd,
   output logic [2:0]  spc7110_blocke,
   output logic [2:0]  spc7110_blockf,
   output logic        ROM_REQ,
   output logic [23:0] ROM_REQ_ADDR,
   input  logic        ROM_ACK,
   input  logic [7:0]  ROM_DATA
);

   logic       sram_en_q, sram_en_d;
   logic [2:0] blockd_q, blockd_d;
   logic [2:0] blocke_q, blocke_d;
   logic [2:0] blockf_q, blockf_d;
   logic [7:0] banked_rd_s;
   logic [7:0] direct_rd_s;

   // Banked window register writes
   always_comb begin
      sram_en_d = sram_en_q;
      blockd_d  = blockd_q;
      blocke_d  = blocke_q;
      blockf_d  = blockf_q;
      if (SNES_WR_END && spc7110_banked_enable) begin
         case (SNES_ADDR)
            8'h30:   sram_en_d = SNES_DATA_IN[7];
            8'h31:   blockd_d  = SNES_DATA_IN[2:0];
            8'h32:   blocke_d  = SNES_DATA_IN[2:0];
            8'h33:   blockf_d  = SNES_DATA_IN[2:0];
            default: sram_en_d = sram_en_q;
         endcase
      end else begin
         sram_en_d = sram_en_q;
      end
   end

   // Banked window read mux
   always_comb begin
      case (SNES_ADDR)
         8'h30:   banked_rd_s = {sram_en_q, 7'b000_0000};
         8'h31:   banked_rd_s = {5'b0_0000, blockd_q};
         8'h32:   banked_rd_s = {5'b0_0000, blocke_q};
         8'h33:   banked_rd_s = {5'b0_0000, blockf_q};
         default: banked_rd_s = 8'h00;
      endcase
   end

   // Banked window state
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sram_en_q <= 1'b0;
         blockd_q  <= 3'd0;
         blocke_q  <= 3'd1;
         blockf_q  <= 3'd2;
      end else begin
         sram_en_q <= sram_en_d;
         blockd_q  <= blockd_d;
         blocke_q  <= blocke_d;
         blockf_q  <= blockf_d;
      end
   end

   assign spc7110_sram_enable = sram_en_q;
   assign spc7110_blockd      = blockd_q;
   assign spc7110_blocke      = blocke_q;
   assign spc7110_blockf      = blockf_q;

`ifdef SPC7110_DIRECT_PORT_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_VALID = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [23:0] p_q, p_d;
   logic [15:0] o_q, o_d;
   logic [15:0] s_q, s_d;
   logic [1:0]  m_q, m_d;
   logic [7:0]  b_q, b_d;
   logic        req_q, req_d;
   logic [23:0] addr_q, addr_d;
   logic [23:0] step_s;
   logic        trigger_s;

   // Pointer increment selected by the mode register
   always_comb begin
      if (!m_q[0]) begin
         step_s = 24'd1;
      end else if (m_q[1]) begin
         step_s = {{8{s_q[15]}}, s_q};
      end else begin
         step_s = {8'h00, s_q};
      end
   end

   // Direct port register writes, pointer advance and fetch sequencing
   always_comb begin
      p_d       = p_q;
      o_d       = o_q;
      s_d       = s_q;
      m_d       = m_q;
      b_d       = b_q;
      state_d   = state_q;
      req_d     = req_q;
      addr_d    = addr_q;
      trigger_s = 1'b0;
      if (SNES_WR_END && spc7110_direct_enable) begin
         case (SNES_ADDR)
            8'h11:   p_d[7:0]   = SNES_DATA_IN;
            8'h12:   p_d[15:8]  = SNES_DATA_IN;
            8'h13: begin
               p_d[23:16] = SNES_DATA_IN;
               trigger_s  = 1'b1;
            end
            8'h14:   o_d[7:0]   = SNES_DATA_IN;
            8'h15:   o_d[15:8]  = SNES_DATA_IN;
            8'h16:   s_d[7:0]   = SNES_DATA_IN;
            8'h17:   s_d[15:8]  = SNES_DATA_IN;
            8'h18:   m_d        = SNES_DATA_IN[1:0];
            default: trigger_s  = 1'b0;
         endcase
      end else if (SNES_RD_END && spc7110_direct_enable &&
                   (SNES_ADDR == 8'h10) && (state_q == ST_VALID)) begin
         p_d       = p_q + step_s;
         trigger_s = 1'b1;
      end else begin
         trigger_s = 1'b0;
      end
      // A trigger always wins: it drops the request for one cycle (aborting any
      // pending fetch and ignoring a coincident ACK) and then re-requests.
      if (trigger_s) begin
         state_d = ST_FETCH;
         req_d   = 1'b0;
         addr_d  = DROM_BASE + p_d;
      end else if (state_q == ST_FETCH) begin
         if (req_q && ROM_ACK) begin
            b_d     = ROM_DATA;
            req_d   = 1'b0;
            state_d = ST_VALID;
         end else begin
            req_d = 1'b1;
         end
      end else begin
         req_d = 1'b0;
      end
   end

   // Direct window read mux
   always_comb begin
      case (SNES_ADDR)
         8'h10, 8'h1A: direct_rd_s = b_q;
         8'h11:   direct_rd_s = p_q[7:0];
         8'h12:   direct_rd_s = p_q[15:8];
         8'h13:   direct_rd_s = p_q[23:16];
         8'h14:   direct_rd_s = o_q[7:0];
         8'h15:   direct_rd_s = o_q[15:8];
         8'h16:   direct_rd_s = s_q[7:0];
         8'h17:   direct_rd_s = s_q[15:8];
         8'h18:   direct_rd_s = {6'b00_0000, m_q};
         default: direct_rd_s = 8'h00;
      endcase
   end

   // Direct port state
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         p_q     <= 24'd0;
         o_q     <= 16'd0;
         s_q     <= 16'd0;
         m_q     <= 2'd0;
         b_q     <= 8'h00;
         req_q   <= 1'b0;
         addr_q  <= 24'd0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         o_q     <= o_d;
         s_q     <= s_d;
         m_q     <= m_d;
         b_q     <= b_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
      end
   end

   assign ROM_REQ      = req_q;
   assign ROM_REQ_ADDR = addr_q;
`else
   logic unused_s;

   assign direct_rd_s  = 8'h00;
   assign ROM_REQ      = 1'b0;
   assign ROM_REQ_ADDR = 24'd0;
   assign unused_s     = ^{SNES_RD_END, ROM_ACK, ROM_DATA, DROM_BASE};
`endif

   assign SNES_DATA_OUT = spc7110_banked_enable ? banked_rd_s :
                          spc7110_direct_enable ? direct_rd_s : 8'h00;

endmodule
